pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Parametrised program-counter and fetch controller for the pipelined RISC-V core; replaces the bare PC register.
//  Generates the PC and drives a req/ack instruction-memory handshake.
//  Applies stall and branch/jump redirect from later stages.
//  Holds one fetched instruction in a skid buffer when IF/ID is stalled.
// PARAMETERS
//  XLEN          32        address/PC width
//  ILEN          32        instruction width
//  RESET_VECTOR  32'h0     PC value loaded on reset
//  PC_INC        4         sequential PC increment (bytes)
//  TRAP_VECTOR   32'h100   PC loaded on misaligned redirect (PC_MISALIGN_TRAP_EN only)
// PORTS
//  clk              in   1     clock, rising edge
//  rst              in   1     asynchronous, active-high reset
//  stall            in   1     IF/ID cannot accept; hold fetch
//  redirect_valid   in   1     branch/jump resolved taken this cycle
//  redirect_target  in   XLEN  redirect destination
//  imem_req         out  1     fetch request
//  imem_addr        out  XLEN  fetch address (= pc while imem_req=1)
//  imem_ack         in   1     memory accepts req; imem_rdata valid same cycle
//  imem_rdata       in   ILEN  fetched instruction
//  if_valid         out  1     if_instr/if_pc valid to IF/ID; consumed when if_valid & ~stall
//  if_instr         out  ILEN  fetched instruction
//  if_pc            out  XLEN  address of if_instr
//  pc_out           out  XLEN  current PC register
//  misalign_exc     out  1     [PC_MISALIGN_TRAP_EN only] 1-cycle pulse on misaligned redirect
//  misalign_addr    out  XLEN  [PC_MISALIGN_TRAP_EN only] offending target, held until next pulse
// BEHAVIOUR
//  Reset (async): pc=RESET_VECTOR, state=BOOT, kill_pend=0, buffer empty.
//  Reset values: all outputs 0 except pc_out/imem_addr=RESET_VECTOR.
//  Reset mid-transaction abandons the outstanding request; memory must tolerate the dropped req.
//  States:
//   BOOT : imem_req=0, if_valid=0; next cycle -> REQ. Redirect in BOOT: pc<=target, still -> REQ.
//   REQ  : imem_req=1, imem_addr=pc. Addr stays stable until ack; req never drops without ack.
//    ack & (redirect_valid|kill_pend): data discarded, if_valid=0, pc<=target (new redirect wins over pending), kill_pend<=0, stay REQ.
//    ack & ~kill & ~stall: if_valid=1, if_instr=imem_rdata, if_pc=pc (combinational, 0 latency), pc<=pc+PC_INC, stay REQ.
//    ack & ~kill & stall: buffer<= {imem_rdata,pc}, pc<=pc+PC_INC, -> HOLD; if_valid=1 same cycle (not consumed).
//    ~ack & redirect_valid: kill_pend<=1, pend_target<=target; later redirect before ack overwrites pend_target.
//    ~ack & stall: no effect (req held).
//   HOLD : imem_req=0, if_valid=1, if_instr/if_pc from buffer.
//    redirect_valid: buffer dropped, pc<=target, -> REQ (priority over stall).
//    ~stall: entry consumed this cycle, -> REQ next cycle.
//  Priority: rst > redirect > stall > sequential.
//  PC arithmetic: modulo 2^XLEN; wraps to 0 with no flag.
//  Without PC_MISALIGN_TRAP_EN, loaded targets have bits [1:0] forced to 0.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined: redirect with target[1:0]!=0 pulses misalign_exc the cycle it is applied, latches misalign_addr, and loads pc<=TRAP_VECTOR instead.
//  PC_MISALIGN_TRAP_EN undefined: misalign ports absent; low bits cleared silently.
// STRUCTURE
//  pc_pkg: state enum {BOOT,REQ,HOLD}, default XLEN/ILEN/RESET_VECTOR/PC_INC constants.
//  Sub-module: existing N_bit_reg instanced for pc and skid buffer. FSM and next-PC mux stay inline.
// TESTING
//  1. rst 1->0, ack every cycle, stall=0 -> BOOT 1 cycle; if_pc 0,4,8,... with if_valid=1 each cycle.
//  2. ack delayed 3 cycles at pc=0x8 -> imem_addr stays 0x8, imem_req stays 1, if_valid=0 until ack.
//  3. redirect 0x40 at pc=0x10, ack arrives 2 cycles later -> 0x10 data dropped (if_valid=0); next req addr 0x40.
//  4. stall=1 when ack at pc=0x20 -> HOLD, if_pc=0x20 held, imem_req=0; stall=0 -> next req 0x24.
//  5. redirect 0x80 in HOLD with stall=1 -> buffer dropped, next req 0x80.
//  6. Redirect to 0x102: macro on -> misalign_exc=1, misalign_addr=0x102, next addr 0x100; macro off -> next addr 0x100, no exc.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and default constants for the PC / instruction-fetch controller.
// Optional misaligned-redirect trap is enabled by the PC_MISALIGN_TRAP_EN macro.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned ILEN_DEF         = 32;
  localparam int unsigned PC_INC_DEF       = 4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

endpackage

// File: rtl/pc_fetch_ctrl_reg.sv
// N-bit register with load enable and asynchronous active-high reset to RST_VAL.
// Used for the PC and for the fetch skid buffer.
module pc_fetch_ctrl_reg #(
  parameter int unsigned  W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC generator and req/ack fetch controller with a one-entry skid buffer for IF/ID stalls.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirects trap to TRAP_VECTOR and report the target.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter int unsigned     ILEN         = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int unsigned     PC_INC       = PC_INC_DEF
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF)
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] pc_out
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr
`endif
);

  state_e state_q, state_d;
  logic kill_pend_q, kill_pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic [XLEN-1:0] pc_q, pc_d, load_src, load_pc;
  logic pc_en, seq_en, load_en, buf_en;
  logic [ILEN+XLEN-1:0] buf_q;

  pc_fetch_ctrl_reg #(.W(XLEN), .RST_VAL(RESET_VECTOR)) u_pc_reg (
    .clk(clk), .rst(rst), .en_i(pc_en), .d_i(pc_d), .q_o(pc_q)
  );

  pc_fetch_ctrl_reg #(.W(ILEN + XLEN), .RST_VAL('0)) u_skid_reg (
    .clk(clk), .rst(rst), .en_i(buf_en), .d_i({imem_rdata, pc_q}), .q_o(buf_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      kill_pend_q <= 1'b0;
      pend_tgt_q  <= '0;
    end else begin
      state_q     <= state_d;
      kill_pend_q <= kill_pend_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

  // A fresh redirect arriving with the ack wins over an older pending one.
  always_comb begin
    state_d     = state_q;
    kill_pend_d = kill_pend_q;
    pend_tgt_d  = pend_tgt_q;
    load_en     = 1'b0;
    load_src    = redirect_target;
    seq_en      = 1'b0;
    buf_en      = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = REQ;
        load_en = redirect_valid;
      end
      REQ: begin
        if (imem_ack) begin
          kill_pend_d = 1'b0;
          if (redirect_valid) begin
            load_en = 1'b1;
          end else if (kill_pend_q) begin
            load_en  = 1'b1;
            load_src = pend_tgt_q;
          end else begin
            seq_en = 1'b1;
            if (stall) begin
              buf_en  = 1'b1;
              state_d = HOLD;
            end
          end
        end else if (redirect_valid) begin
          kill_pend_d = 1'b1;
          pend_tgt_d  = redirect_target;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          load_en = 1'b1;
          state_d = REQ;
        end else if (!stall) begin
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic            misalign;
  logic [XLEN-1:0] misalign_addr_q;

  assign misalign      = load_en && (load_src[1:0] != 2'b00);
  assign load_pc       = misalign ? TRAP_VECTOR : load_src;
  assign misalign_exc  = misalign;
  assign misalign_addr = misalign ? load_src : misalign_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_addr_q <= '0;
    end else if (misalign) begin
      misalign_addr_q <= load_src;
    end
  end
`else
  assign load_pc = load_src & ~XLEN'(3);
`endif

  assign pc_en     = load_en | seq_en;
  assign pc_d      = load_en ? load_pc : pc_q + XLEN'(PC_INC);
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;

  always_comb begin
    imem_req = 1'b0;
    if_valid = 1'b0;
    if_instr = '0;
    if_pc    = '0;
    case (state_q)
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack && !redirect_valid && !kill_pend_q) begin
          if_valid = 1'b1;
          if_instr = imem_rdata;
          if_pc    = pc_q;
        end
      end
      HOLD: begin
        if_valid          = 1'b1;
        {if_instr, if_pc} = buf_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: scoreboard of expected fetches plus per-cycle req/addr/valid checks.
// Build with PC_MISALIGN_TRAP_EN defined to also check the misalign outputs.
module tb_pc_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] pc_out;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_exc;
  logic [31:0] misalign_addr;
`endif

  int     vec_cnt = 0;
  int     err_cnt = 0;
  int     step_no = 0;
  fetch_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (~a) ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .pc_out(pc_out)
`ifdef PC_MISALIGN_TRAP_EN
    , .misalign_exc(misalign_exc), .misalign_addr(misalign_addr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s (step %0d): observed %h expected %h", tag, step_no, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    fetch_t f;
    f.pc    = a;
    f.instr = mem_word(a);
    sb.push_back(f);
  endtask

  // One cycle: drive inputs after the falling edge, check outputs 1ns later.
  task automatic step(input logic st, input logic rv, input logic [31:0] tgt, input logic ack,
                      input logic exp_req, input logic [31:0] exp_addr, input logic exp_vld);
    @(negedge clk);
    step_no++;
    stall = st; redirect_valid = rv; redirect_target = tgt; imem_ack = ack;
    #1;
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, exp_addr);
    chk("if_valid", if_valid, exp_vld);
    if (if_valid === 1'b1) begin
      vec_cnt++;
      assert (sb.size() != 0) else begin
        err_cnt++;
        $error("FAIL unexpected_fetch (step %0d): observed pc %h, expected none", step_no, if_pc);
      end
      if (sb.size() != 0) begin
        chk("if_pc", if_pc, sb[0].pc);
        chk("if_instr", if_instr, sb[0].instr);
        if (!st) void'(sb.pop_front());
      end
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_vld", if_valid, 1'b0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);

    // 1: BOOT for one cycle, then back-to-back fetches
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b1;
    #1;
    chk("boot_req", imem_req, 1'b0);
    chk("boot_vld", if_valid, 1'b0);
    push(32'h0); step(0, 0, 0, 1, 1, 32'h0, 1);
    push(32'h4); step(0, 0, 0, 1, 1, 32'h4, 1);

    // 2: ack delayed 3 cycles at 0x8
    step(0, 0, 0, 0, 1, 32'h8, 0);
    step(1, 0, 0, 0, 1, 32'h8, 0);
    step(0, 0, 0, 0, 1, 32'h8, 0);
    push(32'h8); step(0, 0, 0, 1, 1, 32'h8, 1);
    push(32'hC); step(0, 0, 0, 1, 1, 32'hC, 1);

    // 3: redirect at 0x10 before ack; the late ack's data is dropped
    step(0, 1, 32'h40, 0, 1, 32'h10, 0);
    step(0, 0, 0, 0, 1, 32'h10, 0);
    step(0, 0, 0, 1, 1, 32'h10, 0);
    push(32'h40); step(0, 0, 0, 1, 1, 32'h40, 1);

    // 4: stall at ack of 0x20 -> HOLD, then release
    step(0, 1, 32'h20, 1, 1, 32'h44, 0);
    push(32'h20); step(1, 0, 0, 1, 1, 32'h20, 1);
    step(1, 0, 0, 1, 0, 32'h24, 1);
    step(0, 0, 0, 1, 0, 32'h24, 1);
    push(32'h24); step(0, 0, 0, 1, 1, 32'h24, 1);

    // 5: redirect in HOLD with stall held drops the buffered entry
    push(32'h28); step(1, 0, 0, 1, 1, 32'h28, 1);
    step(1, 1, 32'h80, 1, 0, 32'h2C, 1);
    void'(sb.pop_front());
    push(32'h80); step(0, 0, 0, 1, 1, 32'h80, 1);

    // 6: misaligned redirect target 0x102
    step(0, 1, 32'h102, 1, 1, 32'h84, 0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("misalign_exc_pulse", misalign_exc, 1'b1);
    chk("misalign_addr_pulse", misalign_addr, 32'h102);
`endif
    push(32'h100); step(0, 0, 0, 1, 1, 32'h100, 1);
`ifdef PC_MISALIGN_TRAP_EN
    chk("misalign_exc_clear", misalign_exc, 1'b0);
    chk("misalign_addr_held", misalign_addr, 32'h102);
`endif

    // PC wraps modulo 2^32
    step(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h104, 0);
    push(32'hFFFF_FFFC); step(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 1);
    push(32'h0); step(0, 0, 0, 1, 1, 32'h0, 1);

    // Later redirect before ack overwrites the pending target
    step(0, 1, 32'h300, 0, 1, 32'h4, 0);
    step(0, 1, 32'h400, 0, 1, 32'h4, 0);
    step(0, 0, 0, 1, 1, 32'h4, 0);
    push(32'h400); step(0, 0, 0, 1, 1, 32'h400, 1);

    // Reset mid-transaction, then redirect during BOOT
    step(0, 0, 0, 0, 1, 32'h404, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_pc", pc_out, 32'h0);
    chk("rst2_req", imem_req, 1'b0);
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h200; imem_ack = 1'b1;
    #1;
    chk("boot2_req", imem_req, 1'b0);
    chk("boot2_vld", if_valid, 1'b0);
    push(32'h200); step(0, 0, 0, 1, 1, 32'h200, 1);
    push(32'h204); step(0, 0, 0, 1, 1, 32'h204, 1);

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
